// File: rtl/legv8_defs.sv
// Shared LEGv8 decode constants, ALUOp encodings and control-FSM state encoding.
package legv8_defs;

  localparam logic [10:0] OP_ADD  = 11'b10001011000;
  localparam logic [10:0] OP_SUB  = 11'b11001011000;
  localparam logic [10:0] OP_AND  = 11'b10001010000;
  localparam logic [10:0] OP_ORR  = 11'b10101010000;
  localparam logic [10:0] OP_LDUR = 11'b11111000010;
  localparam logic [10:0] OP_STUR = 11'b11111000000;

  // CBZ and B carry immediate bits inside the 11-bit opcode field
  localparam logic [10:0] CBZ_MASK = 11'b11111111000;
  localparam logic [10:0] CBZ_PAT  = 11'b10110100000;
  localparam logic [10:0] B_MASK   = 11'b11111100000;
  localparam logic [10:0] B_PAT    = 11'b00010100000;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_PASSB = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;

  typedef enum logic [2:0] {
    ST_RST    = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_TRAP   = 3'd6
  } state_t;

  typedef struct packed {
    logic rtype;
    logic ldur;
    logic stur;
    logic cbz;
    logic b;
    logic illegal;
  } op_class_t;

endpackage

// File: rtl/opcode_class_dec.sv
// Combinational opcode classifier: latched 11-bit opcode -> one-hot instruction class.
module opcode_class_dec
  import legv8_defs::*;
(
  input  logic [10:0] i_opcode,
  output op_class_t   o_class
);

  logic w_rtype, w_ldur, w_stur, w_cbz, w_b;

  assign w_rtype = (i_opcode == OP_ADD) || (i_opcode == OP_SUB) ||
                   (i_opcode == OP_AND) || (i_opcode == OP_ORR);
  assign w_ldur  = (i_opcode == OP_LDUR);
  assign w_stur  = (i_opcode == OP_STUR);
  assign w_cbz   = ((i_opcode & CBZ_MASK) == CBZ_PAT);
  assign w_b     = ((i_opcode & B_MASK) == B_PAT);

  assign o_class.rtype   = w_rtype;
  assign o_class.ldur    = w_ldur;
  assign o_class.stur    = w_stur;
  assign o_class.cbz     = w_cbz;
  assign o_class.b       = w_b;
  assign o_class.illegal = ~(w_rtype | w_ldur | w_stur | w_cbz | w_b);

endmodule

// File: rtl/multicycle_control.sv
// LEGv8 multi-cycle main control FSM with retired-instruction counter.
// Build option MCC_ILLEGAL_TRAP_EN: unmatched opcodes trap instead of executing as NOP.
module multicycle_control
  import legv8_defs::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             CLK,
  input  logic             Reset_L,
  input  logic [10:0]      Opcode,
  input  logic             imem_ready,
  input  logic             dmem_ready,
  output logic [1:0]       ALUOp,
  output logic             ALUSrc,
  output logic             Reg2Loc,
  output logic             IRWrite,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             MemToReg,
  output logic             RegWrite,
  output logic             Branch,
  output logic             UncondBranch,
  output logic             PCWrite,
  output logic             illegal,
  output logic [CNT_W-1:0] retired
);

  state_t           r_state, w_next;
  logic [10:0]      r_opcode;
  logic [CNT_W-1:0] r_retired;
  op_class_t        w_class;

  opcode_class_dec u_dec (
    .i_opcode (r_opcode),
    .o_class  (w_class)
  );

  always_ff @(posedge CLK or negedge Reset_L) begin
    if (!Reset_L) begin
      r_state  <= ST_RST;
      r_opcode <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == ST_FETCH && imem_ready) r_opcode <= Opcode;
    end
  end

  always_ff @(posedge CLK or negedge Reset_L) begin
    if (!Reset_L)     r_retired <= '0;
    else if (PCWrite) r_retired <= r_retired + CNT_W'(1);
  end

  assign retired = r_retired;

  always_comb begin
    w_next       = r_state;
    ALUOp        = ALUOP_ADD;
    ALUSrc       = 1'b0;
    Reg2Loc      = 1'b0;
    IRWrite      = 1'b0;
    MemRead      = 1'b0;
    MemWrite     = 1'b0;
    MemToReg     = 1'b0;
    RegWrite     = 1'b0;
    Branch       = 1'b0;
    UncondBranch = 1'b0;
    PCWrite      = 1'b0;
    illegal      = 1'b0;
    case (r_state)
      ST_RST: w_next = ST_FETCH;
      ST_FETCH: begin
        IRWrite = 1'b1;
        if (imem_ready) w_next = ST_DECODE;
      end
      ST_DECODE: begin
        Reg2Loc = w_class.stur | w_class.cbz;
`ifdef MCC_ILLEGAL_TRAP_EN
        w_next  = w_class.illegal ? ST_TRAP : ST_EXEC;
`else
        w_next  = ST_EXEC;
`endif
      end
      ST_EXEC: begin
        // Unmatched opcodes only get here without the trap build: retire as NOP
        if (w_class.illegal) begin
          PCWrite = 1'b1;
          w_next  = ST_FETCH;
        end else if (w_class.rtype) begin
          ALUOp  = ALUOP_RTYPE;
          w_next = ST_WB;
        end else if (w_class.ldur || w_class.stur) begin
          ALUOp  = ALUOP_ADD;
          ALUSrc = 1'b1;
          w_next = ST_MEM;
        end else if (w_class.cbz) begin
          ALUOp   = ALUOP_PASSB;
          Branch  = 1'b1;
          PCWrite = 1'b1;
          w_next  = ST_FETCH;
        end else if (w_class.b) begin
          UncondBranch = 1'b1;
          PCWrite      = 1'b1;
          w_next       = ST_FETCH;
        end
      end
      ST_MEM: begin
        MemRead  = w_class.ldur;
        MemWrite = w_class.stur;
        if (dmem_ready) begin
          if (w_class.ldur) begin
            w_next = ST_WB;
          end else begin
            PCWrite = 1'b1;
            w_next  = ST_FETCH;
          end
        end
      end
      ST_WB: begin
        RegWrite = 1'b1;
        MemToReg = w_class.ldur;
        PCWrite  = 1'b1;
        w_next   = ST_FETCH;
      end
`ifdef MCC_ILLEGAL_TRAP_EN
      ST_TRAP: illegal = 1'b1;
`endif
      default: w_next = ST_RST;
    endcase
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Randomized bench for multicycle_control; per-instruction strobe/latency summary model.
module tb_multicycle_control;

  localparam int CNT_W = 4;

  typedef enum int {C_R, C_L, C_S, C_C, C_B, C_I} cls_e;

  logic             CLK = 1'b0;
  logic             Reset_L = 1'b0;
  logic [10:0]      Opcode = '0;
  logic             imem_ready = 1'b0;
  logic             dmem_ready = 1'b0;
  logic [1:0]       ALUOp;
  logic             ALUSrc, Reg2Loc, IRWrite, MemRead, MemWrite, MemToReg;
  logic             RegWrite, Branch, UncondBranch, PCWrite, illegal;
  logic [CNT_W-1:0] retired;
  logic [12:0]      all_outs;

  int   n_checks = 0;
  int   n_fail = 0;
  int   exp_retired = 0;
  logic prev_pc = 1'b0;

  always #5 CLK = ~CLK;

  multicycle_control #(.CNT_W(CNT_W)) dut (
    .CLK(CLK), .Reset_L(Reset_L), .Opcode(Opcode),
    .imem_ready(imem_ready), .dmem_ready(dmem_ready),
    .ALUOp(ALUOp), .ALUSrc(ALUSrc), .Reg2Loc(Reg2Loc), .IRWrite(IRWrite),
    .MemRead(MemRead), .MemWrite(MemWrite), .MemToReg(MemToReg),
    .RegWrite(RegWrite), .Branch(Branch), .UncondBranch(UncondBranch),
    .PCWrite(PCWrite), .illegal(illegal), .retired(retired)
  );

  assign all_outs = {ALUOp, ALUSrc, Reg2Loc, IRWrite, MemRead, MemWrite,
                     MemToReg, RegWrite, Branch, UncondBranch, PCWrite, illegal};

  function automatic cls_e classify(input logic [10:0] op);
    casez (op)
      11'b10001011000, 11'b11001011000,
      11'b10001010000, 11'b10101010000: return C_R;
      11'b11111000010:                  return C_L;
      11'b11111000000:                  return C_S;
      11'b10110100???:                  return C_C;
      11'b000101?????:                  return C_B;
      default:                          return C_I;
    endcase
  endfunction

  function automatic logic [10:0] gen_op(input int k);
    logic [10:0] rt [4];
    logic [10:0] r;
    rt = '{11'b10001011000, 11'b11001011000, 11'b10001010000, 11'b10101010000};
    case (k)
      0: r = rt[$urandom_range(0, 3)];
      1: r = 11'b11111000010;
      2: r = 11'b11111000000;
      3: r = {8'b10110100, 3'($urandom)};
      4: r = {6'b000101, 5'($urandom)};
      default: begin
        r = 11'($urandom);
        while (classify(r) != C_I) r = 11'($urandom);
      end
    endcase
    return r;
  endfunction

  // One instruction from its FETCH cycle to the cycle after its PCWrite pulse.
  task automatic run_instr(input logic [10:0] op, input int iw, input int dw, input string name);
    cls_e c;
    int   got [12];
    int   exp [12];
    string nm [12];
    int   cyc, ir_cnt, mem_cnt;
    logic in_f, in_m;
    bit   done;
    c = classify(op);
    foreach (got[i]) got[i] = 0;
    cyc = 0; ir_cnt = 0; mem_cnt = 0; done = 0;
    while (!done && cyc < 60) begin
      @(negedge CLK);
      in_f = IRWrite;
      in_m = MemRead | MemWrite;
      imem_ready = in_f ? (ir_cnt == iw) : 1'($urandom_range(0, 1));
      Opcode     = (in_f && imem_ready) ? op : 11'($urandom);
      dmem_ready = in_m ? (mem_cnt == dw) : 1'($urandom_range(0, 1));
      if (in_f) ir_cnt++;
      if (in_m) mem_cnt++;
      #1;
      cyc++;
      got[1]  += int'(IRWrite);   got[2]  += int'(MemRead);
      got[3]  += int'(MemWrite);  got[4]  += int'(RegWrite);
      got[5]  += int'(MemToReg);  got[6]  += int'(Reg2Loc);
      got[7]  += int'(ALUSrc);    got[8]  += int'(Branch);
      got[9]  += int'(UncondBranch);
      got[10] |= int'(ALUOp);     got[11] += int'(illegal);
      n_checks++;
      if (MemRead && MemWrite) begin
        n_fail++; $display("FAIL %s mem_excl: got MemRead=1 MemWrite=1 expected not both", name);
      end
      n_checks++;
      if (PCWrite && prev_pc) begin
        n_fail++; $display("FAIL %s pc_pulse: got PCWrite high 2 cycles expected single pulse", name);
      end
      prev_pc = PCWrite;
      if (PCWrite) done = 1;
    end
    got[0] = cyc;
    n_checks++;
    if (!done) begin
      n_fail++; $display("FAIL %s timeout: got no PCWrite in %0d cycles expected one", name, cyc);
    end
    @(posedge CLK); #1;
    exp_retired = (exp_retired + 1) % (1 << CNT_W);
    n_checks++;
    if (retired !== CNT_W'(exp_retired)) begin
      n_fail++; $display("FAIL %s retired: got %0d expected %0d", name, retired, exp_retired);
    end
    nm  = '{"cycles", "irwrite", "memread", "memwrite", "regwrite", "memtoreg",
            "reg2loc", "alusrc", "branch", "uncond", "aluop", "illegal"};
    exp[0]  = iw + 3 + ((c == C_L) ? dw + 2 : (c == C_S) ? dw + 1 : (c == C_R) ? 1 : 0);
    exp[1]  = iw + 1;
    exp[2]  = (c == C_L) ? dw + 1 : 0;
    exp[3]  = (c == C_S) ? dw + 1 : 0;
    exp[4]  = (c == C_R || c == C_L) ? 1 : 0;
    exp[5]  = (c == C_L) ? 1 : 0;
    exp[6]  = (c == C_S || c == C_C) ? 1 : 0;
    exp[7]  = (c == C_L || c == C_S) ? 1 : 0;
    exp[8]  = (c == C_C) ? 1 : 0;
    exp[9]  = (c == C_B) ? 1 : 0;
    exp[10] = (c == C_R) ? 2 : (c == C_C) ? 1 : 0;
    exp[11] = 0;
    for (int i = 0; i < 12; i++) begin
      n_checks++;
      if (got[i] !== exp[i]) begin
        n_fail++;
        $display("FAIL %s %s: got %0d expected %0d (op=%b iw=%0d dw=%0d)",
                 name, nm[i], got[i], exp[i], op, iw, dw);
      end
    end
  endtask

  task automatic test_reset;
    Reset_L = 1'b0; imem_ready = 1'b0; dmem_ready = 1'b0; Opcode = '0;
    repeat (3) @(negedge CLK);
    n_checks++;
    if (all_outs !== 13'h000) begin
      n_fail++; $display("FAIL reset_outs: got %h expected 000", all_outs);
    end
    n_checks++;
    if (retired !== '0) begin
      n_fail++; $display("FAIL reset_retired: got %0d expected 0", retired);
    end
    Reset_L = 1'b1; #1;
    n_checks++;
    if (all_outs !== 13'h000) begin
      n_fail++; $display("FAIL rst_state_outs: got %h expected 000", all_outs);
    end
    @(posedge CLK); #1;
    n_checks++;
    if (all_outs !== 13'h100) begin
      n_fail++; $display("FAIL fetch_after_rst: got %h expected 100", all_outs);
    end
    exp_retired = 0; prev_pc = 1'b0;
  endtask

  task automatic test_add;         run_instr(11'b10001011000, 0, 0, "add");  endtask
  task automatic test_ldur_wait;   run_instr(11'b11111000010, 0, 2, "ldur"); endtask
  task automatic test_cbz;         run_instr(11'b10110100101, 0, 0, "cbz");  endtask

  task automatic test_back_to_back;
    run_instr(11'b00010100000, 0, 0, "b_b2b");
    run_instr(11'b11111000000, 0, 0, "stur_b2b");
  endtask

  task automatic test_random;
    int k;
    for (int n = 0; n < 40; n++) begin
`ifdef MCC_ILLEGAL_TRAP_EN
      k = $urandom_range(0, 4);
`else
      k = $urandom_range(0, 5);
`endif
      run_instr(gen_op(k), $urandom_range(0, 2), $urandom_range(0, 3), "rand");
    end
  endtask

  task automatic test_reset_mid;
    bit seen;
    seen = 0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge CLK);
      imem_ready = IRWrite;
      Opcode     = IRWrite ? 11'b11111000010 : 11'($urandom);
      dmem_ready = 1'b0;
      #1;
      if (MemRead) seen = 1;
    end
    n_checks++;
    if (!seen) begin
      n_fail++; $display("FAIL rstmid_reach_mem: got no MemRead expected LDUR in MEM");
    end
    #2 Reset_L = 1'b0; #1;
    n_checks++;
    if (all_outs !== 13'h000 || retired !== '0) begin
      n_fail++; $display("FAIL rstmid_abort: got outs=%h retired=%0d expected 000/0", all_outs, retired);
    end
    exp_retired = 0; prev_pc = 1'b0;
    @(negedge CLK);
    Reset_L = 1'b1; imem_ready = 1'b0; #1;
    n_checks++;
    if (all_outs !== 13'h000) begin
      n_fail++; $display("FAIL rstmid_rst: got %h expected 000", all_outs);
    end
    @(posedge CLK); #1;
    n_checks++;
    if (all_outs !== 13'h100 || retired !== '0) begin
      n_fail++; $display("FAIL rstmid_fetch: got outs=%h retired=%0d expected 100/0", all_outs, retired);
    end
  endtask

  task automatic test_illegal;
`ifdef MCC_ILLEGAL_TRAP_EN
    @(negedge CLK);
    imem_ready = 1'b1; Opcode = 11'b11111111111; dmem_ready = 1'b0;
    @(negedge CLK);
    imem_ready = 1'b0; Opcode = 11'($urandom); #1;
    n_checks++;
    if (all_outs !== 13'h000) begin
      n_fail++; $display("FAIL trap_decode: got %h expected 000", all_outs);
    end
    for (int c = 0; c < 4; c++) begin
      @(negedge CLK);
      imem_ready = 1'($urandom_range(0, 1)); dmem_ready = 1'($urandom_range(0, 1));
      #1;
      n_checks++;
      if (all_outs !== 13'h001 || retired !== CNT_W'(exp_retired)) begin
        n_fail++; $display("FAIL trap_hold: got outs=%h retired=%0d expected 001/%0d",
                           all_outs, retired, exp_retired);
      end
    end
`else
    run_instr(11'b11111111111, 0, 0, "nop_illegal");
`endif
  endtask

  initial begin
    test_reset();
    test_add();
    test_ldur_wait();
    test_cbz();
    test_back_to_back();
    test_random();
    test_reset_mid();
    test_illegal();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
